// File: rtl/cop0_pkg.sv
// Shared constants for the cop0 external interrupt/timer controller:
// register map, cause-word bit positions and CTRL bit indices.
package cop0_pkg;

  localparam logic [2:0] INTC_PENDING = 3'd0;
  localparam logic [2:0] INTC_MASK    = 3'd1;
  localparam logic [2:0] INTC_MODE    = 3'd2;
  localparam logic [2:0] INTC_COUNT   = 3'd3;
  localparam logic [2:0] INTC_COMPARE = 3'd4;
  localparam logic [2:0] INTC_CTRL    = 3'd5;

  localparam int CAUSE_IP_LSB    = 10;
  localparam int CAUSE_TIMER_BIT = 15;

  localparam int CTRL_TEN_BIT   = 0;
  localparam int CTRL_TPEND_BIT = 1;

endpackage

// File: rtl/intc_sync_edge.sv
// Single-line synchronizer with a trailing history flop; exposes the
// synchronized level and a one-cycle rising-edge pulse.
module intc_sync_edge
  import cop0_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/cop0_intc.sv
// External interrupt and count/compare timer controller producing the
// registered ext_cause word (IP bits 15:10) consumed by cop0.
module cop0_intc
  import cop0_pkg::*;
#(
  parameter int NUM_IRQ     = 6,
  parameter int SYNC_STAGES = 2,
  parameter int TIMER_EN    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         reg_addr,
  input  logic               reg_wr,
  input  logic [31:0]        reg_wdata,
  input  logic               reg_rd,
  output logic [31:0]        reg_rdata,
  output logic [31:0]        ext_cause,
  output logic               irq_any
);

  logic [NUM_IRQ-1:0] sync, rise;
  logic [NUM_IRQ-1:0] pend_q, pend_d, mask_q, mask_d, mode_q, mode_d, w1c;
  logic [31:0]        cause_q, cause_d, rdata_q, rd_val;
  logic [31:0]        count_w, compare_w;
  logic               ten_w, tpend_w;
  logic               wr_pend, wr_mask, wr_mode, wr_count, wr_compare, wr_ctrl;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    intc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .async_i(irq_in[g]),
      .sync_o (sync[g]),
      .rise_o (rise[g])
    );
  end

  assign wr_pend    = reg_wr && (reg_addr == INTC_PENDING);
  assign wr_mask    = reg_wr && (reg_addr == INTC_MASK);
  assign wr_mode    = reg_wr && (reg_addr == INTC_MODE);
  assign wr_count   = reg_wr && (reg_addr == INTC_COUNT);
  assign wr_compare = reg_wr && (reg_addr == INTC_COMPARE);
  assign wr_ctrl    = reg_wr && (reg_addr == INTC_CTRL);

  // Edge lines hold until W1C, with a coincident rise taking priority;
  // level lines simply track the synchronized input.
  always_comb begin
    w1c    = wr_pend ? (reg_wdata[NUM_IRQ-1:0] & mode_q) : '0;
    pend_d = (mode_q & (rise | (pend_q & ~w1c))) | (~mode_q & sync);
    mask_d = wr_mask ? reg_wdata[NUM_IRQ-1:0] : mask_q;
    mode_d = wr_mode ? reg_wdata[NUM_IRQ-1:0] : mode_q;
  end

  if (TIMER_EN != 0) begin : g_timer
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        ten_q, ten_d, tpend_q, tpend_d;

    always_comb begin
      count_d = count_q;
      if (wr_count)   count_d = reg_wdata;
      else if (ten_q) count_d = count_q + 32'd1;
      compare_d = wr_compare ? reg_wdata : compare_q;
      ten_d     = wr_ctrl ? reg_wdata[CTRL_TEN_BIT] : ten_q;
      tpend_d   = tpend_q;
      if (wr_compare || (wr_ctrl && reg_wdata[CTRL_TPEND_BIT])) tpend_d = 1'b0;
      if (ten_q && (count_q == compare_q)) tpend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        count_q   <= '0;
        compare_q <= '0;
        ten_q     <= 1'b0;
        tpend_q   <= 1'b0;
      end else begin
        count_q   <= count_d;
        compare_q <= compare_d;
        ten_q     <= ten_d;
        tpend_q   <= tpend_d;
      end
    end

    assign count_w   = count_q;
    assign compare_w = compare_q;
    assign ten_w     = ten_q;
    assign tpend_w   = tpend_q;
  end else begin : g_no_timer
    assign count_w   = '0;
    assign compare_w = '0;
    assign ten_w     = 1'b0;
    assign tpend_w   = 1'b0;
  end

  always_comb begin
    rd_val = '0;
    case (reg_addr)
      INTC_PENDING: rd_val = 32'(pend_q);
      INTC_MASK:    rd_val = 32'(mask_q);
      INTC_MODE:    rd_val = 32'(mode_q);
      INTC_COUNT:   rd_val = count_w;
      INTC_COMPARE: rd_val = compare_w;
      INTC_CTRL: begin
        rd_val[CTRL_TEN_BIT]   = ten_w;
        rd_val[CTRL_TPEND_BIT] = tpend_w;
      end
      default:      rd_val = '0;
    endcase
  end

  // Timer pending bypasses the line mask; cop0's IM bits gate it downstream.
  always_comb begin
    cause_d = '0;
    cause_d[CAUSE_IP_LSB +: NUM_IRQ] = pend_q & mask_q;
    cause_d[CAUSE_TIMER_BIT] = cause_d[CAUSE_TIMER_BIT] | tpend_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      cause_q <= '0;
      rdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      cause_q <= cause_d;
      if (reg_rd) rdata_q <= rd_val;
    end
  end

  assign reg_rdata = rdata_q;
  assign ext_cause = cause_q;
  assign irq_any   = |cause_q[CAUSE_TIMER_BIT:CAUSE_IP_LSB];

endmodule

// File: tb/tb_cop0_intc.sv
// Bench for cop0_intc: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_cop0_intc;

  localparam int N  = 6;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  irq_in = '0;
  logic [2:0]    reg_addr = '0;
  logic          reg_wr = 1'b0;
  logic          reg_rd = 1'b0;
  logic [31:0]   reg_wdata = '0;
  logic [31:0]   reg_rdata, ext_cause;
  logic          irq_any;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  cop0_intc #(.NUM_IRQ(N), .SYNC_STAGES(SS), .TIMER_EN(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .reg_addr (reg_addr),
    .reg_wr   (reg_wr),
    .reg_wdata(reg_wdata),
    .reg_rd   (reg_rd),
    .reg_rdata(reg_rdata),
    .ext_cause(ext_cause),
    .irq_any  (irq_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Behavioural model: input history queue stands in for the synchronizer.
  logic [N-1:0] m_pend = '0, m_mask = '0, m_mode = '0;
  logic [31:0]  m_count = '0, m_cmp = '0, m_cause = '0, m_rdata = '0;
  logic         m_ten = 1'b0, m_tpend = 1'b0;
  logic [N-1:0] hist[$];

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      3'd0: v = 32'(m_pend);
      3'd1: v = 32'(m_mask);
      3'd2: v = 32'(m_mode);
      3'd3: v = m_count;
      3'd4: v = m_cmp;
      3'd5: v = {30'd0, m_tpend, m_ten};
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin : model
    logic [N-1:0] sync, prev, npend;
    logic [31:0]  ncause, ncount;
    logic         ntpend;
    if (reset) begin
      m_pend = '0; m_mask = '0; m_mode = '0;
      m_count = '0; m_cmp = '0; m_cause = '0; m_rdata = '0;
      m_ten = 1'b0; m_tpend = 1'b0;
      hist.delete();
      for (int k = 0; k <= SS; k++) hist.push_back('0);
    end else begin
      sync = hist[SS-1];
      prev = hist[SS];
      for (int i = 0; i < N; i++) begin
        if (m_mode[i])
          npend[i] = (sync[i] && !prev[i]) ||
                     (m_pend[i] && !(reg_wr && reg_addr == 3'd0 && reg_wdata[i]));
        else
          npend[i] = sync[i];
      end
      ncause = '0;
      for (int i = 0; i < N; i++)
        if (m_pend[i] && m_mask[i]) ncause[10+i] = 1'b1;
      if (m_tpend) ncause[15] = 1'b1;
      ntpend = m_tpend;
      if (reg_wr && (reg_addr == 3'd4 || (reg_addr == 3'd5 && reg_wdata[1]))) ntpend = 1'b0;
      if (m_ten && m_count == m_cmp) ntpend = 1'b1;
      ncount = m_ten ? m_count + 32'd1 : m_count;
      if (reg_wr && reg_addr == 3'd3) ncount = reg_wdata;
      if (reg_rd) m_rdata = m_read(reg_addr);
      if (reg_wr && reg_addr == 3'd1) m_mask = reg_wdata[N-1:0];
      if (reg_wr && reg_addr == 3'd2) m_mode = reg_wdata[N-1:0];
      if (reg_wr && reg_addr == 3'd4) m_cmp = reg_wdata;
      if (reg_wr && reg_addr == 3'd5) m_ten = reg_wdata[0];
      m_pend  = npend;
      m_count = ncount;
      m_tpend = ntpend;
      m_cause = ncause;
      hist.push_front(irq_in);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ext_cause", ext_cause, m_cause);
      check("cyc_irq_any", {31'd0, irq_any}, {31'd0, |m_cause[15:10]});
      check("cyc_reg_rdata", reg_rdata, m_rdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    reg_rd = 1'b1; reg_addr = a;
    @(negedge clk);
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  initial begin
    logic [31:0] d;
    tick(3);
    chk_en = 1'b1;
    check("rst_cause", ext_cause, 32'h0);
    check("rst_rdata", reg_rdata, 32'h0);
    check("rst_irq_any", {31'd0, irq_any}, 32'h0);
    reset = 1'b0;

    // Level mode latency, rise and fall.
    wr(3'd1, 32'h01);
    irq_in = 6'h01;
    tick(3); check("lvl_pre", ext_cause, 32'h0);
    tick(1); check("lvl_on", ext_cause, 32'h400);
    irq_in = 6'h00;
    tick(3); check("lvl_hold", ext_cause, 32'h400);
    tick(1); check("lvl_off", ext_cause, 32'h0);

    // Edge mode, W1C, and set-beats-clear.
    wr(3'd2, 32'h3F);
    wr(3'd1, 32'h3F);
    irq_in = 6'h04; tick(1); irq_in = 6'h00;
    tick(3); check("edge_set", ext_cause, 32'h1000);
    tick(5); check("edge_hold", ext_cause, 32'h1000);
    wr(3'd0, 32'h04);
    tick(1); check("edge_w1c", ext_cause, 32'h0);
    irq_in = 6'h04; tick(1); irq_in = 6'h00;
    tick(3); check("edge_reset", ext_cause, 32'h1000);
    irq_in = 6'h04; tick(1); irq_in = 6'h00; tick(1);
    wr(3'd0, 32'h04);
    tick(2); check("edge_set_wins", ext_cause, 32'h1000);

    // Masked pending stays visible in PENDING.
    wr(3'd1, 32'h0);
    wr(3'd0, 32'h3F);
    irq_in = 6'h02; tick(1); irq_in = 6'h00;
    tick(4); check("mask_cause", ext_cause, 32'h0);
    rd(3'd0, d); check("mask_pend_rd", d, 32'h02);
    wr(3'd1, 32'h02);
    tick(1); check("unmask_cause", ext_cause, 32'h800);

    // Timer compare match.
    wr(3'd4, 32'd10);
    wr(3'd3, 32'd0);
    wr(3'd5, 32'h1);
    tick(11); check("tmr_pre", ext_cause, 32'h800);
    tick(1);  check("tmr_set", ext_cause, 32'h8800);
    rd(3'd5, d); check("tmr_ctrl", d, 32'h3);
    wr(3'd4, 32'hFFFF0000);
    tick(1); check("tmr_cmp_clr", ext_cause, 32'h800);
    wr(3'd5, 32'h0);

    // Count wrap.
    wr(3'd3, 32'hFFFFFFFE);
    wr(3'd4, 32'h1);
    wr(3'd5, 32'h1);
    tick(1);
    rd(3'd5, d); check("wrap_ctrl_pre", d, 32'h1);
    rd(3'd3, d); check("wrap_cnt0", d, 32'h0);
    rd(3'd3, d); check("wrap_cnt1", d, 32'h1);
    rd(3'd5, d); check("wrap_ctrl_set", d, 32'h3);

    // Reset in the middle of counting.
    reset = 1'b1; tick(1); reset = 1'b0;
    check("rst2_cause", ext_cause, 32'h0);
    check("rst2_rdata", reg_rdata, 32'h0);
    rd(3'd3, d); check("rst2_count", d, 32'h0);
    rd(3'd5, d); check("rst2_ctrl", d, 32'h0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom % 4 == 0) irq_in = 6'($urandom);
      reg_wr    = ($urandom % 3 == 0);
      reg_rd    = ($urandom % 2 == 0);
      reg_addr  = 3'($urandom);
      reg_wdata = ($urandom % 4 == 0) ? $urandom : $urandom_range(0, 40);
      reset     = ($urandom % 600 == 0);
      @(negedge clk);
    end
    reset = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cop0_intc.md
Name: cop0_intc

Overview:
- External interrupt and timer controller sitting directly upstream of the coprocessor-0 unit.
- Synchronizes raw interrupt lines and applies per-line edge/level detection and masking.
- Adds a count/compare timer and drives the 32-bit external-cause word consumed as cop0's ext_cause_in (IP bits 15:10).
- Software configures it through a small word-addressed register port on the scalar data bus.

Parameters:
- NUM_IRQ, 6: number of hardware interrupt lines, mapped to cause bits 10..10+NUM_IRQ-1; legal range 1..6.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizer; legal range 2..3.
- TIMER_EN, 1: 1 = timer present and ORed into cause bit 15; 0 = timer logic removed, COUNT/COMPARE read 0.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  NUM_IRQ  asynchronous external interrupt lines, active high.
- reg_addr  in  3  word address within the register map.
- reg_wr  in  1  write strobe, one cycle per write.
- reg_wdata  in  32  write data.
- reg_rd  in  1  read strobe.
- reg_rdata  out  32  read data, valid the cycle after reg_rd.
- ext_cause  out  32  to cop0 ext_cause_in.
- irq_any  out  1  OR of ext_cause[15:10], for debug/wake.

Behaviour:
- Reset: every register, synchronizer flop, reg_rdata, ext_cause and irq_any = 0 (MODE = level, MASK = all masked, timer disabled).
- Register map:
  - 0 PENDING: read; write-1-to-clear, edge-mode bits only.
  - 1 MASK: RW, bits [NUM_IRQ-1:0].
  - 2 MODE: RW; bit = 1 selects edge mode.
  - 3 COUNT: RW.
  - 4 COMPARE: RW; any write clears timer pending.
  - 5 CTRL: bit0 = timer enable, bit1 = timer pending (read; W1C).
  - Addresses 6-7 read 0; writes to them are ignored.
  - Unused bits read 0.
- Synchronizer: irq_in passes through SYNC_STAGES flops to give sync[i]. A further flop, prev[i], is kept for edge detection.
- Per-line pending:
  - Level mode: pend[i] = sync[i], registered.
  - Edge mode: set when sync[i] & ~prev[i]; cleared by W1C.
  - Simultaneous edge and W1C in the same cycle: set wins.
  - Changing MODE from edge to level: pend follows sync from the next cycle.
- Timer (TIMER_EN = 1):
  - COUNT increments by 1 each cycle while CTRL.bit0 = 1, modulo 2^32 (0xFFFFFFFF wraps to 0 with no side effect).
  - A software COUNT write in the same cycle as an increment: the written value wins.
  - tpend is set in the cycle after COUNT == COMPARE while the timer is enabled, and holds until a COMPARE write or CTRL.bit1 W1C.
  - Set and clear in the same cycle: set wins.
  - COUNT == COMPARE with the timer disabled does not set tpend.
- Cause output, registered, one cycle after pend/tpend change:
  - ext_cause[10+i] = pend[i] & mask[i].
  - ext_cause[15] additionally ORs tpend (tpend is not masked here; cop0 status IM masks it).
  - All other bits are 0 (software IP bits 9:8 belong to cop0).
- Latency: irq_in rising to ext_cause bit set = SYNC_STAGES + 2 cycles for both edge and level mode.
- Read port:
  - reg_rdata is registered, one-cycle latency; it holds its value when reg_rd = 0.
  - Read and write to the same address in the same cycle returns the old value.
  - A PENDING read is not destructive.
- Reset mid-operation: all state returns to reset values in that cycle; pending edges are lost.

Decomposition:
- Shared package cop0_pkg holds:
  - Register address constants INTC_PENDING..INTC_CTRL.
  - CAUSE_IP_LSB = 10 and CAUSE_TIMER_BIT = 15.
  - CTRL bit indices.
- One sub-module, intc_sync_edge: per-line synchronizer plus prev flop, outputs sync and rise. Instantiate it NUM_IRQ times via generate.

Test Plan:
- Level mode: MASK = 0x01, hold irq_in[0] = 1 -> ext_cause = 0x00000400 after 4 cycles (SYNC_STAGES = 2). Drop irq_in[0] -> returns to 0 after 4 cycles.
- Edge mode and W1C:
  - MODE = 0x3F, MASK = 0x3F, pulse irq_in[2] for 1 cycle -> ext_cause = 0x00001000 and stays.
  - Write PENDING = 0x04 -> 0 the next cycle.
  - Re-pulse irq_in[2] in the same cycle as the W1C -> bit stays set.
- Mask: MASK = 0, edge on irq_in[1] -> ext_cause = 0 but PENDING reads 0x02. Then write MASK = 0x02 -> ext_cause = 0x00000800.
- Timer: COMPARE = 10, COUNT = 0, CTRL = 1 -> ext_cause[15] rises on the cycle after COUNT reaches 10 and CTRL reads 0x3. A COMPARE write clears it.
- Wrap: COUNT = 0xFFFFFFFE, COMPARE = 1, enable -> COUNT reads 0 then 1 and tpend sets with no spurious set at wrap. Assert reset mid-count -> COUNT, CTRL and ext_cause read 0.
